tile_stream_engine: RTL and testbench

Parametrised tile-transfer engine for the NPU image path. It walks a source image in square tiles, reads each tile from a synchronous source memory (image ROM) with a pipelined read, optionally applies a per-pixel operation, and writes the tile to a destination memory (image RAM) scanned by the VGA controller. It supports continuous and single-step modes, and it flags each completed tile and the completed frame.

---
 rtl/tile_stream_engine.sv | 163 ++++++++++++++++
 tb/tb_tile_stream_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_stream_engine.sv
// tile_stream_engine: walks an image in square tiles, reading each tile from a pipelined
// source ROM into a buffer and writing it back out to a destination RAM with an optional pixel op.
module tile_stream_engine #(
    parameter int IMG_W  = 400,
    parameter int IMG_H  = 400,
    parameter int TILE   = 10,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          step,
    input  logic [1:0]                    mode,
    input  logic [DATA_W-1:0]             thr,
    output logic [ADDR_W-1:0]             src_addr,
    output logic                          src_rd,
    input  logic [DATA_W-1:0]             src_data,
    output logic [ADDR_W-1:0]             dst_addr,
    output logic [DATA_W-1:0]             dst_data,
    output logic                          dst_wren,
    output logic                          busy,
    output logic                          tile_done,
    output logic                          done,
    output logic [$clog2(IMG_W/TILE)-1:0] tile_x,
    output logic [$clog2(IMG_H/TILE)-1:0] tile_y
);
    localparam int NTX = IMG_W / TILE;
    localparam int NTY = IMG_H / TILE;
    localparam int NPX = TILE * TILE;
    localparam int CW  = $clog2(TILE);
    localparam int IW  = $clog2(NPX);
    localparam int XW  = $clog2(NTX);
    localparam int YW  = $clog2(NTY);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, WRITE, NEXT, FINISH, WAIT_STEP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     r, c, r_n, c_n, r_adv, c_adv;
    logic [2:0]        dcnt, dcnt_n;
    logic              cont, cont_n, last_px, last_col, last_tile;
    logic [XW-1:0]     tx_n;
    logic [YW-1:0]     ty_n;
    logic [ADDR_W-1:0] pa;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] thr_q, px, wr_d;
    logic [IW-1:0]     rd_idx;
    logic [DATA_W-1:0] tbuf [NPX];
    logic [RD_LAT-1:0] vsr;
    logic [IW-1:0]     isr [RD_LAT];

    assign last_col  = c == CW'(TILE - 1);
    assign last_px   = last_col && r == CW'(TILE - 1);
    assign last_tile = tile_x == XW'(NTX - 1) && tile_y == YW'(NTY - 1);
    assign c_adv     = last_col ? '0 : c + 1'b1;
    assign r_adv     = last_px ? '0 : last_col ? r + 1'b1 : r;

    always_comb begin
        state_n = state;
        r_n     = r;
        c_n     = c;
        dcnt_n  = dcnt;
        cont_n  = cont;
        tx_n    = tile_x;
        ty_n    = tile_y;
        case (state)
            IDLE, WAIT_STEP: if (start || step) begin
                state_n = LOAD;
                r_n     = '0;
                c_n     = '0;
                cont_n  = start;
            end
            LOAD: begin
                state_n = last_px ? DRAIN : LOAD;
                r_n     = r_adv;
                c_n     = c_adv;
                dcnt_n  = '0;
            end
            DRAIN: begin
                state_n = dcnt == 3'(RD_LAT - 1) ? WRITE : DRAIN;
                dcnt_n  = dcnt + 3'd1;
            end
            WRITE: begin
                state_n = last_px ? NEXT : WRITE;
                r_n     = r_adv;
                c_n     = c_adv;
            end
            NEXT: begin
                state_n = last_tile ? FINISH : cont ? LOAD : WAIT_STEP;
                tx_n    = tile_x == XW'(NTX - 1) ? '0 : tile_x + 1'b1;
                ty_n    = last_tile ? '0 : tile_x == XW'(NTX - 1) ? tile_y + 1'b1 : tile_y;
            end
            default: state_n = IDLE;
        endcase
    end

    // Addresses and write data are formed from next-state indices so every output is registered.
    assign pa     = (ADDR_W'(ty_n) * ADDR_W'(TILE) + ADDR_W'(r_n)) * ADDR_W'(IMG_W)
                  + ADDR_W'(tx_n) * ADDR_W'(TILE) + ADDR_W'(c_n);
    assign px     = tbuf[IW'(r_n) * IW'(TILE) + IW'(c_n)];
    assign wr_d   = mode_q == 2'b01 ? ~px : mode_q == 2'b10 ? {DATA_W{px >= thr_q}} : px;
    assign rd_idx = IW'(r) * IW'(TILE) + IW'(c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            dcnt      <= '0;
            cont      <= 1'b0;
            tile_x    <= '0;
            tile_y    <= '0;
            src_addr  <= '0;
            src_rd    <= 1'b0;
            dst_addr  <= '0;
            dst_data  <= '0;
            dst_wren  <= 1'b0;
            busy      <= 1'b0;
            tile_done <= 1'b0;
            done      <= 1'b0;
            mode_q    <= '0;
            thr_q     <= '0;
            vsr       <= '0;
        end else begin
            state     <= state_n;
            r         <= r_n;
            c         <= c_n;
            dcnt      <= dcnt_n;
            cont      <= cont_n;
            tile_x    <= tx_n;
            tile_y    <= ty_n;
            src_rd    <= state_n == LOAD;
            dst_wren  <= state_n == WRITE;
            busy      <= state_n != IDLE && state_n != WAIT_STEP;
            tile_done <= state_n == NEXT;
            vsr       <= RD_LAT'({vsr, src_rd});
            if (state_n == LOAD)
                src_addr <= pa;
            if (state_n == WRITE) begin
                dst_addr <= pa;
                dst_data <= wr_d;
            end
            if (state_n == FINISH)
                done <= 1'b1;
            else if (state_n == LOAD && (state == IDLE || state == WAIT_STEP))
                done <= 1'b0;
            if (state_n == LOAD && state != LOAD) begin
                mode_q <= mode;
                thr_q  <= thr;
            end
        end
    end

    // Index pipeline travels with vsr; data lands in the buffer as the delayed valid emerges.
    always_ff @(posedge clk) begin
        isr[0] <= rd_idx;
        for (int i = 1; i < RD_LAT; i++)
            isr[i] <= isr[i-1];
        if (vsr[RD_LAT-1])
            tbuf[isr[RD_LAT-1]] <= src_data;
    end
endmodule

// File: tb/tb_tile_stream_engine.sv
// tb_tile_stream_engine: scoreboard bench for one default-size engine and four small engines
// (RD_LAT 1..4) driven with identical stimulus.
module tb_tile_stream_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] f(input logic [9:0] a);
        return 8'(a * 29 + 3);
    endfunction

    function automatic logic [7:0] op(input logic [7:0] p, input logic [1:0] m, input logic [7:0] t);
        return m == 2'b01 ? ~p : m == 2'b10 ? (p >= t ? 8'hFF : 8'h00) : p;
    endfunction

    // default-size engine
    logic        rst_b, b_start, b_step, b_sr, b_dw, b_bz, b_td, b_dn;
    logic [1:0]  b_mode;
    logic [7:0]  b_thr, b_sd, b_dd;
    logic [18:0] b_sa, b_da, bp0, bp1;
    logic [5:0]  b_tx, b_ty;

    tile_stream_engine u_big (
        .clk(clk), .rst(rst_b), .start(b_start), .step(b_step), .mode(b_mode), .thr(b_thr),
        .src_addr(b_sa), .src_rd(b_sr), .src_data(b_sd), .dst_addr(b_da), .dst_data(b_dd),
        .dst_wren(b_dw), .busy(b_bz), .tile_done(b_td), .done(b_dn), .tile_x(b_tx), .tile_y(b_ty)
    );

    always @(posedge clk) begin
        bp0 <= b_sa;
        bp1 <= bp0;
    end
    assign b_sd = bp1[7:0];

    // small engines, 20x20 image in 4x4 tiles, index g has RD_LAT g+1
    logic             rst, s_start, s_step;
    logic [1:0]       s_mode;
    logic [7:0]       s_thr;
    logic [3:0][9:0]  s_sa, s_da;
    logic [3:0][7:0]  s_sd, s_dd;
    logic [3:0][2:0]  s_tx, s_ty;
    logic [3:0]       s_sr, s_dw, s_bz, s_td, s_dn;

    for (genvar g = 0; g < 4; g++) begin : gs
        localparam int L = g + 1;
        logic [9:0] p [L];
        tile_stream_engine #(
            .IMG_W(20), .IMG_H(20), .TILE(4), .DATA_W(8), .ADDR_W(10), .RD_LAT(L)
        ) u_dut (
            .clk(clk), .rst(rst), .start(s_start), .step(s_step), .mode(s_mode), .thr(s_thr),
            .src_addr(s_sa[g]), .src_rd(s_sr[g]), .src_data(s_sd[g]), .dst_addr(s_da[g]),
            .dst_data(s_dd[g]), .dst_wren(s_dw[g]), .busy(s_bz[g]), .tile_done(s_td[g]),
            .done(s_dn[g]), .tile_x(s_tx[g]), .tile_y(s_ty[g])
        );
        always @(posedge clk) begin
            p[0] <= s_sa[g];
            for (int i = 1; i < L; i++)
                p[i] <= p[i-1];
        end
        assign s_sd[g] = f(p[L-1]);
    end

    logic [17:0] exp_q[$];
    logic [26:0] big_q[$];
    int t0 = 0;
    int bt0 = 0;
    int rp[4] = '{default: 0};
    int kk[4] = '{default: 0};
    int ph[4] = '{default: -1};
    logic [3:0] dn_q = '0;

    always @(negedge clk) begin
        int per;
        for (int g = 0; g < 4; g++) begin
            per = 34 + g;
            if (s_dw[g]) begin
                if (rp[g] < exp_q.size()) begin
                    chk($sformatf("sm%0d_write", g), {s_da[g], s_dd[g]}, exp_q[rp[g]]);
                    rp[g]++;
                end else begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sm%0d_extra_write: got addr %0d expected no write", g, s_da[g]);
                end
            end
            if (s_td[g]) begin
                if (ph[g] != t0) begin
                    ph[g] = t0;
                    kk[g] = 0;
                end
                kk[g]++;
                chk($sformatf("sm%0d_tile_done_cycle", g), cyc, t0 + kk[g] * per);
            end
            if (s_dn[g] && !dn_q[g])
                chk($sformatf("sm%0d_done_cycle", g), cyc, t0 + kk[g] * per + 1);
            dn_q[g] = s_dn[g];
        end
        if (b_dw) begin
            if (big_q.size() > 0)
                chk("big_write", {b_da, b_dd}, big_q.pop_front());
            else begin
                n_vec++;
                n_bad++;
                $display("FAIL big_extra_write: got addr %0d expected no write", b_da);
            end
        end
        if (b_td)
            chk("big_tile_done_cycle", cyc, bt0 + 203);
    end

    task automatic push_tile(input int tx, input int ty, input logic [1:0] m, input logic [7:0] t);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                logic [9:0] a;
                a = 10'((ty * 4 + r) * 20 + tx * 4 + c);
                exp_q.push_back({a, op(f(a), m, t)});
            end
    endtask

    task automatic pulse_small(input logic st, input logic sp);
        @(negedge clk);
        s_start = st;
        s_step  = sp;
        t0      = cyc;
        @(negedge clk);
        s_start = 1'b0;
        s_step  = 1'b0;
    endtask

    task automatic wait_small(input int budget, input logic need_done);
        int n;
        logic ok;
        for (n = 0; n < budget; n++) begin
            ok = need_done ? s_dn == 4'hF : s_bz == 4'h0;
            for (int g = 0; g < 4; g++)
                ok = ok && rp[g] == exp_q.size();
            if (ok)
                break;
            @(negedge clk);
        end
        chk("sm_wait_bound", n < budget, 1);
    endtask

    initial begin
        int n;
        int act;
        rst = 1'b1; rst_b = 1'b1;
        s_start = 1'b0; s_step = 1'b0; s_mode = 2'b00; s_thr = 8'h00;
        b_start = 1'b0; b_step = 1'b0; b_mode = 2'b00; b_thr = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("big_reset_ctl", {b_bz, b_dn, b_dw, b_sr, b_td, b_tx, b_ty}, 0);
        chk("big_reset_addr", {b_sa | b_da, b_dd}, 0);
        for (int g = 0; g < 4; g++)
            chk($sformatf("sm%0d_reset", g),
                {s_bz[g], s_dn[g], s_dw[g], s_sr[g], s_td[g], s_tx[g], s_ty[g], s_sa[g]}, 0);

        // default engine: one stepped tile with copy, src[a] = a[7:0]
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                big_q.push_back({19'(r * 400 + c), 8'(r * 400 + c)});
        @(negedge clk);
        b_step = 1'b1;
        bt0    = cyc;
        @(negedge clk);
        b_step = 1'b0;
        for (n = 0; n < 400 && !(big_q.size() == 0 && !b_bz); n++)
            @(negedge clk);
        chk("big_step_bound", n < 400, 1);
        chk("big_tile_xy", {b_tx, b_ty}, {6'd1, 6'd0});
        chk("big_wait_step", {b_bz, b_dn, b_sr, b_dw}, 0);

        // reset in the middle of the second tile's write phase
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                big_q.push_back({19'(r * 400 + 10 + c), 8'(r * 400 + 10 + c)});
        @(negedge clk);
        b_step = 1'b1;
        bt0    = cyc;
        @(negedge clk);
        b_step = 1'b0;
        for (n = 0; n < 300 && !b_dw; n++)
            @(negedge clk);
        chk("big_write_bound", n < 300, 1);
        repeat (5) @(negedge clk);
        #1 rst_b = 1'b1;
        #1 chk("big_async_reset", {b_dw, b_bz, b_dn, b_sr, b_tx, b_ty}, 0);
        big_q.delete();
        @(negedge clk);
        rst_b = 1'b0;
        act = 0;
        repeat (30) begin
            @(negedge clk);
            act += int'(b_sr) + int'(b_dw);
        end
        chk("big_quiet_after_reset", act, 0);
        chk("big_idle_after_reset", {b_bz, b_dn, b_tx, b_ty}, 0);

        // small engines: invert on tile 0
        push_tile(0, 0, 2'b01, 8'h00);
        s_mode = 2'b01;
        pulse_small(1'b0, 1'b1);
        wait_small(300, 1'b0);
        for (int g = 0; g < 4; g++)
            chk($sformatf("sm%0d_xy_after_step", g), {s_tx[g], s_ty[g]}, {3'd1, 3'd0});

        // threshold on tile 1; mode change mid-tile must not take effect
        push_tile(1, 0, 2'b10, 8'h80);
        s_mode = 2'b10;
        s_thr  = 8'h80;
        pulse_small(1'b0, 1'b1);
        repeat (4) @(negedge clk);
        s_mode = 2'b00;
        s_thr  = 8'h00;
        wait_small(300, 1'b0);
        for (int g = 0; g < 4; g++)
            chk($sformatf("sm%0d_xy_tile2", g), {s_tx[g], s_ty[g], s_bz[g]}, {3'd2, 3'd0, 1'b0});

        // start from WAIT_STEP: remaining tiles back-to-back
        for (int ty = 0; ty < 5; ty++)
            for (int tx = 0; tx < 5; tx++)
                if (ty * 5 + tx >= 2)
                    push_tile(tx, ty, 2'b00, 8'h00);
        pulse_small(1'b1, 1'b0);
        wait_small(2000, 1'b1);
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++)
            chk($sformatf("sm%0d_finish_state", g), {s_tx[g], s_ty[g], s_bz[g], s_dn[g]}, 1);

        // start and step together from IDLE: full continuous frame
        for (int ty = 0; ty < 5; ty++)
            for (int tx = 0; tx < 5; tx++)
                push_tile(tx, ty, 2'b11, 8'h00);
        s_mode = 2'b11;
        pulse_small(1'b1, 1'b1);
        for (int g = 0; g < 4; g++)
            chk($sformatf("sm%0d_done_cleared", g), {s_dn[g], s_bz[g]}, 2'b01);
        wait_small(2000, 1'b1);
        chk("big_queue_drained", big_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
